load_store_unit: RTL and testbench

//  Sits between the core's execute stage (ALUResult/WriteData/funct3) and a

---
 rtl/load_store_unit.sv | 211 +++++++++++++++++++++
 tb/tb_load_store_unit.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// RV32I load/store unit: turns core accesses (lb/lh/lw/lbu/lhu/sb/sh/sw) into
// word-wide memory requests with byte strobes, extends load data and reports errors.
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  dbg_state
);

  // Core side: an access transfers on a rising edge where req_valid && req_ready.
  // Memory side: mem_req is held with stable address/data until the edge where
  // mem_ack is sampled high (or the timeout abort). The response is a single
  // resp_valid cycle with no back-pressure.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  off_q, off_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [3:0]  mem_wstrb_q, mem_wstrb_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        resp_err_q, resp_err_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;

  logic        req_legal;
  logic        req_misaligned;
  logic [3:0]  st_strb;
  logic [31:0] st_data;
  logic [31:0] ld_shifted;
  logic [15:0] ld_half;
  logic [31:0] ld_value;
  logic        timeout_hit;

  // Request decode: funct3[1:0] is the access size, funct3[2] the unsigned flag.
  always_comb begin
    req_legal      = 1'b0;
    req_misaligned = 1'b0;
    st_strb        = 4'b0000;
    st_data        = 32'd0;
    if (req_we) req_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
                            (req_funct3 == 3'b010);
    else        req_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
                            (req_funct3 == 3'b010) || (req_funct3 == 3'b100) ||
                            (req_funct3 == 3'b101);
    case (req_funct3[1:0])
      2'b00: begin
        st_strb = 4'b0001 << req_addr[1:0];
        st_data = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        req_misaligned = req_addr[0];
        st_strb        = 4'b0011 << req_addr[1:0];
        st_data        = {2{req_wdata[15:0]}};
      end
      2'b10: begin
        req_misaligned = (req_addr[1:0] != 2'b00);
        st_strb        = 4'b1111;
        st_data        = req_wdata;
      end
      default: begin
        req_misaligned = 1'b0;
        st_strb        = 4'b0000;
        st_data        = 32'd0;
      end
    endcase
  end

  // Load lane extraction uses the byte offset latched at accept time.
  always_comb begin
    ld_shifted = mem_rdata >> {off_q, 3'b000};
    ld_half    = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (funct3_q)
      3'b000:  ld_value = {{24{ld_shifted[7]}}, ld_shifted[7:0]};
      3'b001:  ld_value = {{16{ld_half[15]}}, ld_half};
      3'b010:  ld_value = mem_rdata;
      3'b100:  ld_value = {24'd0, ld_shifted[7:0]};
      3'b101:  ld_value = {16'd0, ld_half};
      default: ld_value = 32'd0;
    endcase
  end

  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    funct3_d     = funct3_q;
    off_d        = off_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wstrb_d  = mem_wstrb_q;
    mem_wdata_d  = mem_wdata_q;
    resp_err_d   = resp_err_q;
    resp_rdata_d = resp_rdata_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d     = req_we;
          funct3_d = req_funct3;
          off_d    = req_addr[1:0];
          if (!req_legal || req_misaligned) begin
            state_d      = RESP;
            resp_err_d   = 1'b1;
            resp_rdata_d = 32'd0;
          end else begin
            state_d     = WAIT;
            cnt_d       = '0;
            mem_req_d   = 1'b1;
            mem_we_d    = req_we;
            mem_addr_d  = {req_addr[31:2], 2'b00};
            mem_wstrb_d = req_we ? st_strb : 4'b0000;
            mem_wdata_d = req_we ? st_data : 32'd0;
          end
        end
      end
      WAIT: begin
        // An ack in the final counted cycle still completes normally.
        if (mem_ack || timeout_hit) begin
          state_d      = RESP;
          cnt_d        = '0;
          mem_req_d    = 1'b0;
          mem_we_d     = 1'b0;
          mem_addr_d   = 32'd0;
          mem_wstrb_d  = 4'b0000;
          mem_wdata_d  = 32'd0;
          resp_err_d   = !mem_ack;
          resp_rdata_d = (mem_ack && !we_q) ? ld_value : 32'd0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        state_d      = IDLE;
        resp_err_d   = 1'b0;
        resp_rdata_d = 32'd0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      funct3_q     <= 3'b000;
      off_q        <= 2'b00;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= 32'd0;
      mem_wstrb_q  <= 4'b0000;
      mem_wdata_q  <= 32'd0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      we_q         <= we_d;
      funct3_q     <= funct3_d;
      off_q        <= off_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wstrb_q  <= mem_wstrb_d;
      mem_wdata_q  <= mem_wdata_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wstrb  = mem_wstrb_q;
  assign mem_wdata  = mem_wdata_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed spec cases, then random
// accesses compared against an arithmetic reference model.
module tb_load_store_unit;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [1:0]  dbg_state;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  load_store_unit #(.TIMEOUT_CYCLES(TIMEOUT), .CNT_W(5)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model from the access rules, using plain arithmetic.
  task automatic ref_model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [31:0] rd,
                           output logic err, output logic [31:0] exp_rd,
                           output logic [31:0] exp_strb, output logic [31:0] exp_wd);
    int size;
    int ofs;
    logic [31:0] v;
    ofs  = int'(addr % 4);
    size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    if (we) err = !(f3 == 0 || f3 == 1 || f3 == 2);
    else    err = !(f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
    if (!err && (ofs % size) != 0) err = 1'b1;
    exp_strb = 0;
    exp_wd   = 0;
    exp_rd   = 0;
    if (we) begin
      exp_strb = ((32'd1 << size) - 1) << ofs;
      if (size == 1)      exp_wd = (wd & 32'hFF) * 32'h01010101;
      else if (size == 2) exp_wd = (wd & 32'hFFFF) * 32'h00010001;
      else                exp_wd = wd;
    end else begin
      v = rd >> (8 * ofs);
      if (size == 1) begin
        exp_rd = v & 32'hFF;
        if (f3 == 0 && exp_rd >= 32'h80) exp_rd = exp_rd | 32'hFFFFFF00;
      end else if (size == 2) begin
        exp_rd = v & 32'hFFFF;
        if (f3 == 1 && exp_rd >= 32'h8000) exp_rd = exp_rd | 32'hFFFF0000;
      end else begin
        exp_rd = rd;
      end
    end
  endtask

  // One complete access; ack_dly = WAIT cycle index of the ack (>= TIMEOUT means none).
  task automatic access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] rd, input int ack_dly);
    logic        e;
    logic [31:0] er, es, ew;
    logic        done;
    logic        tmo;
    ref_model(we, f3, addr, wd, rd, e, er, es, ew);
    tmo = (ack_dly >= TIMEOUT);
    chk("ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
    if (e) begin
      chk("err_valid", {31'd0, resp_valid}, 32'd1);
      chk("err_flag", {31'd0, resp_err}, 32'd1);
      chk("err_rdata", resp_rdata, 32'd0);
      chk("err_no_memreq", {31'd0, mem_req}, 32'd0);
    end else begin
      done = 1'b0;
      for (int k = 0; k < TIMEOUT && !done; k++) begin
        chk("wait_memreq", {31'd0, mem_req}, 32'd1);
        chk("wait_no_resp", {31'd0, resp_valid}, 32'd0);
        if (k == 0) begin
          chk("mem_addr", mem_addr, addr & 32'hFFFFFFFC);
          chk("mem_we", {31'd0, mem_we}, {31'd0, we});
          chk("mem_wstrb", {28'd0, mem_wstrb}, es);
          chk("mem_wdata", mem_wdata, ew);
        end
        if (k == ack_dly) begin
          mem_ack = 1'b1; mem_rdata = rd;
        end else begin
          mem_rdata = $urandom;
        end
        @(posedge clk); #1;
        mem_ack = 1'b0;
        if (k == ack_dly) done = 1'b1;
      end
      chk("resp_valid", {31'd0, resp_valid}, 32'd1);
      chk("resp_err", {31'd0, resp_err}, {31'd0, tmo});
      chk("resp_rdata", resp_rdata, tmo ? 32'd0 : er);
      chk("resp_memreq_low", {31'd0, mem_req}, 32'd0);
      if (tmo) begin
        mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;
      end
    end
    @(posedge clk); #1;
    mem_ack = 1'b0;
    chk("after_no_resp", {31'd0, resp_valid}, 32'd0);
    chk("after_ready", {31'd0, req_ready}, 32'd1);
    chk("after_memreq_low", {31'd0, mem_req}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'd0; req_wdata = 32'd0; mem_ack = 1'b0; mem_rdata = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Directed cases
    access(1'b0, 3'b010, 32'h64, 32'd0, 32'h00000019, 0);
    access(1'b0, 3'b000, 32'h63, 32'd0, 32'h80FF1234, 1);
    access(1'b0, 3'b100, 32'h63, 32'd0, 32'h80FF1234, 0);
    access(1'b0, 3'b001, 32'h62, 32'd0, 32'h80FF1234, 2);
    access(1'b0, 3'b101, 32'h62, 32'd0, 32'h80FF1234, 0);
    access(1'b1, 3'b000, 32'h61, 32'h000000AB, 32'd0, 0);
    access(1'b1, 3'b001, 32'h62, 32'h1234BEEF, 32'd0, 3);
    access(1'b1, 3'b010, 32'h68, 32'hCAFEF00D, 32'd0, 0);
    access(1'b0, 3'b010, 32'h66, 32'd0, 32'd0, 0);
    access(1'b0, 3'b011, 32'h64, 32'd0, 32'd0, 0);
    access(1'b1, 3'b100, 32'h64, 32'd0, 32'd0, 0);
    access(1'b1, 3'b001, 32'h63, 32'd0, 32'd0, 0);
    access(1'b0, 3'b010, 32'h70, 32'd0, 32'h12345678, TIMEOUT);
    access(1'b0, 3'b010, 32'h74, 32'd0, 32'h87654321, TIMEOUT - 1);

    // Reset while waiting on memory abandons the access
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h80;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("pre_rst_memreq", {31'd0, mem_req}, 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("mid_rst_memreq", {31'd0, mem_req}, 32'd0);
    chk("mid_rst_no_resp", {31'd0, resp_valid}, 32'd0);
    chk("mid_rst_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    chk("post_rst_no_resp", {31'd0, resp_valid}, 32'd0);
    access(1'b1, 3'b000, 32'h83, 32'h5A, 32'd0, 0);
    access(1'b0, 3'b001, 32'h80, 32'd0, 32'h0000F00F, 0);

    // Randomized accesses
    for (int i = 0; i < 60; i++) begin
      logic        r_we;
      logic [2:0]  r_f3;
      int          r_dly;
      r_we  = 1'($urandom_range(0, 1));
      r_f3  = 3'($urandom_range(0, 7));
      r_dly = (i % 15 == 7) ? $urandom_range(TIMEOUT - 1, TIMEOUT + 2) : $urandom_range(0, 4);
      access(r_we, r_f3, $urandom, $urandom, $urandom, r_dly);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
